// File: rtl/mux32_serializer.sv
// mux32_serializer: holds a 32-bit word on a 32:1 mux and walks its select to stream one bit per transfer
// Ports: clk/rst_n (sync active-low); in_data/in_valid/in_ready word input handshake;
// mux_a/mux_sel drive the external mux, mux_y is its output; ser_bit/ser_valid/ser_ready/ser_last
// form the serial stream; done pulses one cycle after the final bit of a word is accepted.
module mux32_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mux_a,
  output logic [4:0]  mux_sel,
  input  logic        mux_y,
  output logic        ser_bit,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_last,
  output logic        done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [4:0] SEL_START = LSB_FIRST ? 5'd0 : 5'd31;
  state_t     state, state_nxt;
  logic [4:0] cnt;
  logic       accept, xfer, last_xfer;
  assign accept    = in_valid & in_ready;
  assign xfer      = ser_valid & ser_ready;
  assign last_xfer = xfer & (cnt == 5'd31);
  assign ser_bit   = mux_y;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // a last-bit transfer with a waiting word stays in SHIFT so the next word has no bubble
  always_comb
    state_nxt = (state == IDLE) ? (accept ? SHIFT : IDLE) :
                (last_xfer & ~in_valid) ? IDLE : SHIFT;
  always_comb begin
    ser_valid = (state == SHIFT);
    ser_last  = ser_valid & (cnt == 5'd31);
    in_ready  = (state == IDLE) | (ser_last & ser_ready);
  end
  // select is only ever reloaded at word start, so it never wraps within a word
  always_ff @(posedge clk)
    if (!rst_n) begin
      mux_a   <= '0;
      mux_sel <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= last_xfer;
      if (accept) begin
        mux_a   <= in_data;
        mux_sel <= SEL_START;
        cnt     <= '0;
      end else if (xfer & ~last_xfer) begin
        cnt     <= cnt + 5'd1;
        mux_sel <= LSB_FIRST ? mux_sel + 5'd1 : mux_sel - 5'd1;
      end
    end
endmodule

// File: tb/tb_mux32_serializer.sv
// tb_mux32_serializer: checks LSB-first and MSB-first instances side by side against a word-level model
module tb_mux32_serializer;
  logic        clk, rst_n, in_valid, ser_ready, tog;
  logic [31:0] in_data;
  logic        ir0, ir1, y0, y1, b0, b1, sv0, sv1, last0, last1, done0, done1;
  logic [31:0] a0, a1;
  logic [4:0]  sel0, sel1;
  int tests = 0, fails = 0, nxfer = 0;
  logic        chk_en = 0;
  logic        m_busy = 0, m_done = 0;
  logic [31:0] m_word = 0, rx0 = 0, rx1 = 0;
  logic [4:0]  m_n = 0;
  typedef struct {
    logic [31:0] word;
    logic [3:0]  rpat;
    logic        first_lsb;
    logic        first_msb;
  } vec_t;
  vec_t vecs[6];
  assign y0 = a0[sel0] ^ tog;
  assign y1 = a1[sel1] ^ tog;
  mux32_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
    .mux_a(a0), .mux_sel(sel0), .mux_y(y0), .ser_bit(b0), .ser_valid(sv0),
    .ser_ready(ser_ready), .ser_last(last0), .done(done0));
  mux32_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .mux_a(a1), .mux_sel(sel1), .mux_y(y1), .ser_bit(b1), .ser_valid(sv1),
    .ser_ready(ser_ready), .ser_last(last1), .done(done1));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic check_outputs();
    logic ir;
    ir = !m_busy || (m_n == 5'd31 && ser_ready);
    chk1("in_ready_lsb", ir0, ir);
    chk1("in_ready_msb", ir1, ir);
    chk1("ser_valid_lsb", sv0, m_busy);
    chk1("ser_valid_msb", sv1, m_busy);
    chk1("ser_last_lsb", last0, m_busy && m_n == 5'd31);
    chk1("ser_last_msb", last1, m_busy && m_n == 5'd31);
    chk1("done_lsb", done0, m_done);
    chk1("done_msb", done1, m_done);
    chk("mux_a_lsb", a0, m_word);
    chk("mux_a_msb", a1, m_word);
    if (m_busy) begin
      chk("sel_lsb", 32'(sel0), 32'(m_n));
      chk("sel_msb", 32'(sel1), 32'(5'd31 - m_n));
      chk1("bit_lsb", b0, m_word[m_n]);
      chk1("bit_msb", b1, m_word[5'd31 - m_n]);
      if (ser_ready) begin
        rx0[m_n] = b0;
        rx1[5'd31 - m_n] = b1;
        if (m_n == 5'd31) begin
          chk("reassembled_lsb", rx0, m_word);
          chk("reassembled_msb", rx1, m_word);
        end
      end
    end
    if (sv0 && ser_ready) nxfer++;
  endtask
  task automatic model_update();
    logic fin, acc;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_word = 0; m_n = 0;
    end else begin
      fin = m_busy && ser_ready && m_n == 5'd31;
      acc = in_valid && (!m_busy || fin);
      m_done = fin;
      if (acc) begin
        m_word = in_data; m_n = 0; m_busy = 1;
      end else if (m_busy && ser_ready) begin
        if (fin) m_busy = 0;
        else     m_n = m_n + 5'd1;
      end
    end
  endtask
  task automatic tick();
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] w, input logic [3:0] rp, input logic f0, input logic f1);
    int k;
    in_data = w; in_valid = 1; ser_ready = rp[0];
    tick();
    in_valid = 0;
    nxfer = 0;
    chk1("first_bit_lsb", b0, f0);
    chk1("first_bit_msb", b1, f1);
    k = 0;
    while (m_busy && k < 300) begin
      ser_ready = rp[k[1:0]];
      tick();
      k++;
    end
    if (k >= 300) chk1("send_timeout", m_busy, 1'b0);
    chk("xfer_count", nxfer, 32);
    chk1("done_pulse", done0, 1'b1);
    ser_ready = 0;
    tick();
    chk1("done_cleared", done0, 1'b0);
  endtask
  initial begin
    int vcnt, dcnt, t1, t2;
    vecs[0] = '{32'hA5A5_0F0F, 4'b1111, 1'b1, 1'b1};
    vecs[1] = '{32'h8000_0001, 4'b1111, 1'b1, 1'b1};
    vecs[2] = '{32'hDEAD_BEEF, 4'b1001, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0003, 4'b1111, 1'b1, 1'b0};
    vecs[4] = '{32'h1234_5678, 4'b0110, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_0000, 4'b1011, 1'b0, 1'b1};
    rst_n = 0; in_valid = 0; in_data = 0; ser_ready = 0; tog = 0;
    @(negedge clk);
    repeat (2) tick();
    chk_en = 1;
    chk("reset_sel_lsb", 32'(sel0), 0);
    chk("reset_sel_msb", 32'(sel1), 0);
    chk("reset_mux_a", a0, 0);
    chk1("reset_ser_valid", sv0, 1'b0);
    chk1("reset_done", done0, 1'b0);
    chk1("reset_in_ready", ir0, 1'b1);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tog = i[0];
      ser_ready = i[1];
      tick();
    end
    tog = 0;
    chk1("idle_ser_valid", sv1, 1'b0);
    for (int i = 0; i < 6; i++) send(vecs[i].word, vecs[i].rpat, vecs[i].first_lsb, vecs[i].first_msb);
    in_data = 32'h1234_5678; in_valid = 1; ser_ready = 1;
    tick();
    in_data = 32'hFFFF_0000;
    vcnt = 0; dcnt = 0; t1 = -1; t2 = -1;
    for (int i = 0; i < 66; i++) begin
      if (sv0) vcnt++;
      if (done0) begin
        dcnt++;
        if (t1 < 0) t1 = i; else t2 = i;
      end
      tick();
      if (i == 31) in_valid = 0;
    end
    chk("b2b_valid_cycles", vcnt, 64);
    chk("b2b_done_count", dcnt, 2);
    chk("b2b_done_spacing", t2 - t1, 32);
    in_data = 32'hCAFE_F00D; in_valid = 1; ser_ready = 1;
    tick();
    in_valid = 0;
    repeat (10) tick();
    rst_n = 0;
    tick();
    chk1("midreset_ser_valid", sv0, 1'b0);
    chk1("midreset_done", done0, 1'b0);
    chk("midreset_sel_msb", 32'(sel1), 0);
    chk("midreset_mux_a", a1, 0);
    rst_n = 1;
    tick();
    chk1("midreset_no_done", done1, 1'b0);
    send(32'h0000_0003, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data = $urandom;
      ser_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1; in_valid = 0; ser_ready = 1;
    repeat (40) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
